al422_pixel_writer_3bytes: RTL and testbench
============================================

Name: al422_pixel_writer_3bytes

Overview:
- Write side of the AL422 frame FIFO link. Accepts 24-bit RGB pixels over a valid/ready handshake.
- Serialises each pixel into 3 consecutive bytes (R, G, B), issuing AL422 write-enable and write-reset signals.
- Byte order and 3-cycle cadence match the 3-bytes-per-pixel LED readout path, so readout regroups bytes as rgb = {R, G, B}.
- Sits between the frame source (host/SPI loader) and the AL422 write port.

Parameters:
- PIXELS_PER_FRAME, 2048, pixels written between write-reset and frame_done.
- WRST_CYCLES, 4, cycles al_wrst_n held low at frame start (min 1).

Ports:
- in_clk  input  1  system clock; all logic on rising edge.
- in_rst  input  1  reset, synchronous, active-high.
- frame_start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- frame_abort  input  1  forces return to IDLE from any state.
- pix_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
- pix_valid  input  1  pix_data valid.
- pix_ready  output  1  pixel accepted when pix_valid & pix_ready.
- al_data  output  8  byte to AL422 DI.
- al_we_n  output  1  AL422 write enable, active-low.
- al_wrst_n  output  1  AL422 write pointer reset, active-low.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when the last byte of a frame is written.

Behaviour:
- Reset (in_rst sampled high at posedge):
  - state = IDLE.
  - al_data = 8'h00, al_we_n = 1, al_wrst_n = 1, pix_ready = 0, busy = 0, frame_done = 0.
  - All counters = 0.
- All outputs are registered.
- States:
  - IDLE -> WRST on frame_start.
  - WRST: al_wrst_n = 0 for exactly WRST_CYCLES cycles, al_we_n = 1; then -> STREAM.
  - STREAM: pixels accepted and serialised; pixel counter pix_cnt runs 0..PIXELS_PER_FRAME-1.
  - DONE: one cycle, frame_done = 1; then -> IDLE.
- Byte serialiser, STREAM state:
  - Internal byte_idx 0..2 plus a sending flag.
  - Pixel accepted at posedge N gives, with al_we_n = 0:
    - al_data = R during cycle N+1
    - al_data = G during cycle N+2
    - al_data = B during cycle N+3
- pix_ready is high in STREAM when pix_cnt < PIXELS_PER_FRAME and either:
  - the serialiser is idle, or
  - it is emitting byte_idx 2.
  - This gives back-to-back pixels with 1 pixel / 3 cycles peak throughput and no gap cycles.
- Underflow:
  - If pix_valid is low when ready, al_we_n = 1 and al_data holds its last value.
  - No filler bytes are written.
  - A pixel is never split: once R is written, G and B follow on the next two cycles unconditionally.
- Frame end:
  - When the accepted-pixel count reaches PIXELS_PER_FRAME, pix_ready drops.
  - After the final B byte, the FSM enters DONE, so frame_done is high the cycle after the final B.
- Counter widths: $clog2(PIXELS_PER_FRAME+1) for pix_cnt and $clog2(WRST_CYCLES+1) for the WRST counter. No wrap inside a frame.
- frame_start outside IDLE: ignored, no queuing.
- frame_abort:
  - Next cycle: state = IDLE, al_we_n = 1, al_wrst_n = 1, pix_ready = 0, no frame_done.
  - A partially sent pixel is truncated.
  - frame_abort has priority over frame_start and over any pixel handshake in the same cycle.
- Simultaneous frame_abort and in_rst: reset wins; both lead to the same IDLE values.

Optional Feature:
- Macro: AL422_WRITER_TEST_PATTERN_EN.
- With the macro defined:
  - Extra input port test_mode (1 bit).
  - When test_mode = 1 in STREAM, pix_data and pix_valid are ignored and pix_ready stays 0.
  - An internal pattern pixel is treated as always valid: R = pix_cnt[7:0], G = ~pix_cnt[7:0], B = 8'h00 when pix_cnt is even, 8'hFF when odd.
  - Timing is identical to the normal path (3 cycles/pixel, back-to-back).
  - test_mode is sampled only at pixel acceptance boundaries.
- Without the macro: no test_mode port, no pattern logic.

Test Plan:
- Reset then idle: hold in_rst 2 cycles -> al_we_n = 1, al_wrst_n = 1, pix_ready = 0, busy = 0; frame_start with pix_valid = 0 -> al_wrst_n low exactly 4 cycles, then busy = 1 and pix_ready = 1.
- Single pixel: PIXELS_PER_FRAME = 1, pix_data = 24'h123456 -> al_we_n low 3 cycles with al_data 8'h12, 8'h34, 8'h56; frame_done pulses the next cycle; state returns to IDLE.
- Back-to-back: PIXELS_PER_FRAME = 4, pix_valid held high with pixels 0xAA0011, 0xBB0022, 0xCC0033, 0xDD0044 -> 12 consecutive we_n-low cycles with bytes in order; pix_ready high every 3rd cycle; exactly one frame_done.
- Underflow: pix_valid dropped 5 cycles between pixel 1 and pixel 2 -> al_we_n high for those gap cycles after B of pixel 1; no extra bytes; total we_n-low count = 3 × PIXELS_PER_FRAME.
- Abort: frame_abort asserted on the G byte of pixel 2 -> next cycle al_we_n = 1, busy = 0, no frame_done; a following frame_start performs a fresh write-reset.
- Ignored start and reset mid-stream: frame_start pulsed during STREAM -> no effect; in_rst asserted mid-pixel -> all outputs at reset values at the next edge.

Source files
------------

// File: rtl/al422_pixel_writer_3bytes.sv
// al422_pixel_writer_3bytes: serialises 24-bit RGB pixels into R,G,B bytes on the AL422 write port.
// Optional test pattern source enabled by defining AL422_WRITER_TEST_PATTERN_EN.
module al422_pixel_writer_3bytes #(
    parameter int PIXELS_PER_FRAME = 2048,
    parameter int WRST_CYCLES = 4
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        frame_start,
    input  logic        frame_abort,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
`ifdef AL422_WRITER_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        pix_ready,
    output logic [7:0]  al_data,
    output logic        al_we_n,
    output logic        al_wrst_n,
    output logic        busy,
    output logic        frame_done
);
    localparam int CW = $clog2(PIXELS_PER_FRAME + 1);
    localparam int WW = $clog2(WRST_CYCLES + 1);
    localparam logic [CW-1:0] PPF = CW'(PIXELS_PER_FRAME);
    localparam logic [WW-1:0] WLAST = WW'(WRST_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, WRST, STREAM, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] pix_cnt, pix_cnt_nx;
    logic [WW-1:0] wrst_cnt, wrst_cnt_nx;
    logic [1:0] byte_idx, byte_idx_nx;
    logic sending, sending_nx;
    logic [15:0] gb, gb_nx;
    logic [7:0] al_data_nx;
    logic we_n_nx, wrst_n_nx, slot_nx, ready_nx, acc;
    logic [23:0] src;
`ifdef AL422_WRITER_TEST_PATTERN_EN
    logic slot;
    logic [7:0] pc8;
    assign pc8 = 8'(pix_cnt);
`endif
    always_comb begin
        state_nx = state;
        pix_cnt_nx = pix_cnt;
        wrst_cnt_nx = wrst_cnt;
        byte_idx_nx = byte_idx;
        sending_nx = sending;
        gb_nx = gb;
        al_data_nx = al_data;
        we_n_nx = 1'b1;
        wrst_n_nx = 1'b1;
        acc = pix_ready & pix_valid;
        src = pix_data;
`ifdef AL422_WRITER_TEST_PATTERN_EN
        if (slot & test_mode & ~pix_ready) begin
            acc = 1'b1;
            src = {pc8, ~pc8, {8{pix_cnt[0]}}};
        end
`endif
        case (state)
            IDLE: if (frame_start) begin
                state_nx = WRST;
                wrst_cnt_nx = '0;
                wrst_n_nx = 1'b0;
            end
            WRST: if (wrst_cnt == WLAST) begin
                state_nx = STREAM;
                pix_cnt_nx = '0;
                sending_nx = 1'b0;
                byte_idx_nx = '0;
            end else begin
                wrst_cnt_nx = wrst_cnt + 1'b1;
                wrst_n_nx = 1'b0;
            end
            STREAM: if (acc) begin
                al_data_nx = src[23:16];
                gb_nx = src[15:0];
                we_n_nx = 1'b0;
                sending_nx = 1'b1;
                byte_idx_nx = '0;
                pix_cnt_nx = pix_cnt + 1'b1;
            end else if (sending && byte_idx != 2'd2) begin
                // once R is out, G and B follow unconditionally
                byte_idx_nx = byte_idx + 1'b1;
                al_data_nx = (byte_idx == 2'd0) ? gb[15:8] : gb[7:0];
                we_n_nx = 1'b0;
            end else begin
                sending_nx = 1'b0;
                byte_idx_nx = '0;
                state_nx = (sending && pix_cnt == PPF) ? DONE : STREAM;
            end
            DONE: state_nx = IDLE;
        endcase
        if (frame_abort) begin
            state_nx = IDLE;
            we_n_nx = 1'b1;
            wrst_n_nx = 1'b1;
            sending_nx = 1'b0;
            byte_idx_nx = '0;
        end
        slot_nx = (state_nx == STREAM) && (pix_cnt_nx < PPF) && (!sending_nx || byte_idx_nx == 2'd2);
`ifdef AL422_WRITER_TEST_PATTERN_EN
        ready_nx = slot_nx & ~test_mode;
`else
        ready_nx = slot_nx;
`endif
    end
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= IDLE;
            pix_cnt <= '0;
            wrst_cnt <= '0;
            byte_idx <= '0;
            sending <= 1'b0;
            gb <= '0;
            al_data <= 8'h00;
            al_we_n <= 1'b1;
            al_wrst_n <= 1'b1;
            pix_ready <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
`ifdef AL422_WRITER_TEST_PATTERN_EN
            slot <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            pix_cnt <= pix_cnt_nx;
            wrst_cnt <= wrst_cnt_nx;
            byte_idx <= byte_idx_nx;
            sending <= sending_nx;
            gb <= gb_nx;
            al_data <= al_data_nx;
            al_we_n <= we_n_nx;
            al_wrst_n <= wrst_n_nx;
            pix_ready <= ready_nx;
            busy <= state_nx != IDLE;
            frame_done <= state_nx == DONE;
`ifdef AL422_WRITER_TEST_PATTERN_EN
            slot <= slot_nx;
`endif
        end
    end
endmodule

// File: tb/tb_al422_pixel_writer_3bytes.sv
// tb_al422_pixel_writer_3bytes: directed bench for the AL422 3-byte pixel writer.
// Two instances: frame length 4 (main) and frame length 1 (single-pixel frame).
module tb_al422_pixel_writer_3bytes;
    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    logic frame_start = 1'b0, frame_start1 = 1'b0, frame_abort = 1'b0, pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic pix_ready, al_we_n, al_wrst_n, busy, frame_done;
    logic [7:0] al_data;
    logic d1_ready, d1_we_n, d1_wrst_n, d1_busy, d1_done;
    logic [7:0] d1_data;
    int checks = 0, errors = 0;
    logic [23:0] pixq[$];
    logic [7:0] got[$];
    int we_cnt, ready_cnt, done_cnt, done_cyc, first_we, last_we, wrst_low;
    int gap_at = -1, gap_len = 0, stop_at = -1, start_at = -1;
    bit stop_abort = 1'b0;

    al422_pixel_writer_3bytes #(.PIXELS_PER_FRAME(4), .WRST_CYCLES(4)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .frame_start(frame_start), .frame_abort(frame_abort),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .al_data(al_data),
        .al_we_n(al_we_n), .al_wrst_n(al_wrst_n), .busy(busy), .frame_done(frame_done));

    al422_pixel_writer_3bytes #(.PIXELS_PER_FRAME(1), .WRST_CYCLES(4)) dut1 (
        .in_clk(in_clk), .in_rst(in_rst), .frame_start(frame_start1), .frame_abort(frame_abort),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(d1_ready), .al_data(d1_data),
        .al_we_n(d1_we_n), .al_wrst_n(d1_wrst_n), .busy(d1_busy), .frame_done(d1_done));

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic start_frame();
        int n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!pix_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!pix_ready) begin
            errors++;
            $display("FAIL start_timeout: pix_ready=%0b after %0d cycles, required 1", pix_ready, n);
        end
    endtask

    task automatic run_stream(input int max_cyc);
        int idx, gap;
        bit acc;
        idx = 0;
        gap = 0;
        got.delete();
        we_cnt = 0; ready_cnt = 0; done_cnt = 0; done_cyc = -1; first_we = -1; last_we = -1; wrst_low = 0;
        pix_data = pixq[0];
        pix_valid = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            frame_start = (c == start_at);
            acc = pix_ready && pix_valid;
            if (pix_ready) ready_cnt++;
            tick();
            if (acc) begin
                idx++;
                if (idx == gap_at) gap = gap_len;
            end
            if (gap > 0) begin
                pix_valid = 1'b0;
                gap--;
            end else begin
                pix_valid = (idx < pixq.size());
                if (idx < pixq.size()) pix_data = pixq[idx];
            end
            if (!al_we_n) begin
                got.push_back(al_data);
                we_cnt++;
                if (first_we < 0) first_we = c;
                last_we = c;
            end
            if (!al_wrst_n) wrst_low++;
            if (frame_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (stop_at > 0 && got.size() == stop_at && !al_we_n) begin
                if (stop_abort) frame_abort = 1'b1;
                else in_rst = 1'b1;
                tick();
                frame_abort = 1'b0;
                in_rst = 1'b0;
                break;
            end
        end
        frame_start = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        in_rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({al_we_n, al_wrst_n, pix_ready, busy, frame_done, al_data} !== {5'b11000, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got we_n=%0b wrst_n=%0b ready=%0b busy=%0b done=%0b data=%0h, required 1 1 0 0 0 00",
                     al_we_n, al_wrst_n, pix_ready, busy, frame_done, al_data);
        end
        checks++;
        if ({d1_we_n, d1_wrst_n, d1_ready, d1_busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_dut1: got %b, required 1100", {d1_we_n, d1_wrst_n, d1_ready, d1_busy});
        end
        in_rst = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !al_wrst_n; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL wrst_length: got %0d cycles low, required 4", n);
        end
        checks++;
        if ({busy, pix_ready, al_we_n} !== 3'b111) begin
            errors++;
            $display("FAIL stream_entry: got busy/ready/we_n=%b, required 111", {busy, pix_ready, al_we_n});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[12] = '{8'hAA, 8'h00, 8'h11, 8'hBB, 8'h00, 8'h22, 8'hCC, 8'h00, 8'h33, 8'hDD, 8'h00, 8'h44};
        pixq = '{24'hAA0011, 24'hBB0022, 24'hCC0033, 24'hDD0044};
        run_stream(20);
        checks++;
        if (we_cnt !== 12 || last_we - first_we !== 11) begin
            errors++;
            $display("FAIL b2b_we_run: got %0d bytes over span %0d, required 12 over 11", we_cnt, last_we - first_we);
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %0h, required %0h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (ready_cnt !== 4) begin
            errors++;
            $display("FAIL b2b_ready: got %0d ready cycles, required 4", ready_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_we + 1) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc, last_we + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] b[$];
        int n, dc, dn;
        frame_start1 = 1'b1;
        tick();
        frame_start1 = 1'b0;
        n = 0;
        while (!d1_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!d1_ready) begin
            errors++;
            $display("FAIL single_ready: got %0b, required 1", d1_ready);
        end
        pix_data = 24'h123456;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        dc = -1;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (!d1_we_n) b.push_back(d1_data);
            if (d1_done) begin
                dn++;
                dc = c;
            end
            tick();
        end
        checks++;
        if (b.size() !== 3) begin
            errors++;
            $display("FAIL single_count: got %0d bytes, required 3", b.size());
        end else begin
            checks++;
            if ({b[0], b[1], b[2]} !== 24'h123456) begin
                errors++;
                $display("FAIL single_bytes: got %0h, required 123456", {b[0], b[1], b[2]});
            end
        end
        checks++;
        if (dn !== 1 || dc !== 3) begin
            errors++;
            $display("FAIL single_done: got %0d pulses at %0d, required 1 at 3", dn, dc);
        end
        checks++;
        if ({d1_busy, d1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: got busy/ready=%b, required 00", {d1_busy, d1_ready});
        end
    endtask

    task automatic test_underflow();
        start_frame();
        pixq = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};
        gap_at = 1;
        gap_len = 5;
        run_stream(40);
        gap_at = -1;
        checks++;
        if (we_cnt !== 12) begin
            errors++;
            $display("FAIL uf_count: got %0d bytes, required 12", we_cnt);
        end
        checks++;
        if ((last_we - first_we + 1) - 12 !== 3) begin
            errors++;
            $display("FAIL uf_gap: got %0d idle cycles, required 3", (last_we - first_we + 1) - 12);
        end
        checks++;
        if (got.size() == 12 && {got[2], got[3], got[11]} !== 24'h3040C0) begin
            errors++;
            $display("FAIL uf_bytes: got %0h, required 3040c0", {got[2], got[3], got[11]});
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_we + 1) begin
            errors++;
            $display("FAIL uf_done: got %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc, last_we + 1);
        end
    endtask

    task automatic test_abort();
        int wl, dn;
        start_frame();
        pixq = '{24'h111213, 24'h212223, 24'h313233, 24'h414243};
        stop_at = 5;
        stop_abort = 1'b1;
        run_stream(40);
        stop_at = -1;
        checks++;
        if (got.size() !== 5 || got[4] !== 8'h22) begin
            errors++;
            $display("FAIL abort_point: got %0d bytes, required 5 ending in 22", got.size());
        end
        checks++;
        if ({al_we_n, al_wrst_n, busy, pix_ready, frame_done} !== 5'b11000) begin
            errors++;
            $display("FAIL abort_outputs: got %b, required 11000", {al_we_n, al_wrst_n, busy, pix_ready, frame_done});
        end
        wl = 0;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!al_we_n) wl++;
            if (frame_done) dn++;
        end
        checks++;
        if (wl !== 0 || dn !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d writes %0d done, required 0 0", wl, dn);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if ({al_wrst_n, busy} !== 2'b01) begin
            errors++;
            $display("FAIL abort_restart: got wrst_n/busy=%b, required 01", {al_wrst_n, busy});
        end
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        checks++;
        if ({al_wrst_n, busy} !== 2'b10) begin
            errors++;
            $display("FAIL abort_wrst: got wrst_n/busy=%b, required 10", {al_wrst_n, busy});
        end
    endtask

    task automatic test_start_and_reset();
        start_frame();
        pixq = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        start_at = 4;
        run_stream(20);
        start_at = -1;
        checks++;
        if (wrst_low !== 0 || we_cnt !== 12 || done_cnt !== 1) begin
            errors++;
            $display("FAIL ignored_start: got wrst_low=%0d bytes=%0d done=%0d, required 0 12 1", wrst_low, we_cnt, done_cnt);
        end
        start_frame();
        stop_at = 2;
        stop_abort = 1'b0;
        run_stream(20);
        stop_at = -1;
        checks++;
        if ({al_we_n, al_wrst_n, pix_ready, busy, frame_done, al_data} !== {5'b11000, 8'h00}) begin
            errors++;
            $display("FAIL midreset: got we_n=%0b wrst_n=%0b ready=%0b busy=%0b done=%0b data=%0h, required 1 1 0 0 0 00",
                     al_we_n, al_wrst_n, pix_ready, busy, frame_done, al_data);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_underflow();
        test_abort();
        test_start_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
